// File: rtl/stl_rst_seq.sv
// Reset sequencer: synchronizes an external reset request, holds all outputs asserted, then releases channels in order.
// Optional software reset request input enabled by macro STL_RST_SWREQ_EN.
module stl_rst_seq #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ASSERT  = 16,
  parameter int RELEASE_GAP = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ext_rst_n,
`ifdef STL_RST_SWREQ_EN
  input  logic              i_sw_rst,
`endif
  output logic [NUM_CH-1:0] o_rst_n,
  output logic              o_done
);

  localparam logic [1:0] S_ASSERT  = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [7:0]        MIN_TC   = 8'(MIN_ASSERT - 1);
  localparam logic [7:0]        GAP_TC   = 8'(RELEASE_GAP - 1);
  localparam logic [4:0]        LAST_IDX = 5'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] CH0      = NUM_CH'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   req;
  logic [1:0]             state;
  logic [7:0]             cnt;
  logic [4:0]             idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_ext_rst_n};
    end
  end

`ifdef STL_RST_SWREQ_EN
  // Software request bypasses the synchronizer: it is already in this clock domain.
  assign req = ~sync[SYNC_STAGES-1] | i_sw_rst;
`else
  assign req = ~sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_ASSERT;
      cnt     <= '0;
      idx     <= '0;
      o_rst_n <= '0;
      o_done  <= 1'b0;
    end else if (req) begin
      // A live request overrides any terminal count reached on the same edge.
      state   <= S_ASSERT;
      cnt     <= '0;
      idx     <= '0;
      o_rst_n <= '0;
      o_done  <= 1'b0;
    end else begin
      case (state)
        S_ASSERT: begin
          if (cnt == MIN_TC) begin
            o_rst_n <= CH0;
            cnt     <= '0;
            idx     <= 5'd1;
            if (NUM_CH == 1) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state <= S_RELEASE;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RELEASE: begin
          if (cnt == GAP_TC) begin
            o_rst_n <= o_rst_n | (CH0 << idx);
            cnt     <= '0;
            idx     <= idx + 5'd1;
            if (idx == LAST_IDX) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          cnt <= '0;
        end
        default: begin
          state   <= S_ASSERT;
          cnt     <= '0;
          idx     <= '0;
          o_rst_n <= '0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stl_rst_seq.sv
// Scoreboard bench for stl_rst_seq: a quiet-time reference model predicts outputs, a negedge monitor compares.
module tb_stl_rst_seq;
  localparam int NCH  = 3;
  localparam int SYNC = 2;
  localparam int MINA = 4;
  localparam int GAP  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ext_n = 1'b1;
  logic           sw = 1'b0;
  logic [NCH-1:0] rst_n;
  logic           done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [NCH:0] exp_q[$];

  // Reference model state: synchronizer delay line and count of consecutive request-free edges.
  logic m_sync[SYNC];
  int   quiet = 0;

  always #5 clk = ~clk;

  stl_rst_seq #(
    .NUM_CH(NCH), .SYNC_STAGES(SYNC), .MIN_ASSERT(MINA), .RELEASE_GAP(GAP)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_ext_rst_n(ext_n),
`ifdef STL_RST_SWREQ_EN
    .i_sw_rst(sw),
`endif
    .o_rst_n(rst_n),
    .o_done(done)
  );

  function automatic logic [NCH:0] predict(int q);
    int n;
    logic [NCH-1:0] v;
    if (q < MINA) n = 0;
    else n = 1 + (q - MINA) / GAP;
    if (n > NCH) n = NCH;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return {(n == NCH), v};
  endfunction

  // Drive inputs for the next edge, advance the model across that edge, queue the expectation.
  task automatic step(input logic e, input logic r, input logic s);
    logic req;
    ext_n = e;
    rst   = r;
`ifdef STL_RST_SWREQ_EN
    sw = s;
`else
    sw = 1'b0;
    req = s;
`endif
    if (r) begin
      for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
      quiet = 0;
    end else begin
      req = (m_sync[SYNC-1] == 1'b0) || (sw == 1'b1);
      for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = e;
      if (req) quiet = 0;
      else if (quiet < 1000) quiet = quiet + 1;
    end
    exp_q.push_back(predict(quiet));
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [NCH:0] exp;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        tests++;
        if (rst_n !== exp[NCH-1:0]) begin
          fails++;
          $display("FAIL rst_n cycle %0d got=%b exp=%b", cyc, rst_n, exp[NCH-1:0]);
        end
        tests++;
        if (done !== exp[NCH]) begin
          fails++;
          $display("FAIL done cycle %0d got=%b exp=%b", cyc, done, exp[NCH]);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL timeout tests=%0d got=running exp=finished", tests);
    $fatal(1, "timeout");
  end

  initial begin : driver
    int lowrun;
    int r;
    for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    repeat (3) step(1'b1, 1'b1, 1'b0);
    // Full sequence from reset release.
    repeat (14) step(1'b1, 1'b0, 1'b0);
    // External request mid-release, then restore.
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (8) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (14) step(1'b1, 1'b0, 1'b0);
    // Request arriving while the assert counter is near terminal.
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (14) step(1'b1, 1'b0, 1'b0);
    // Block reset from DONE.
    step(1'b1, 1'b1, 1'b0);
    repeat (14) step(1'b1, 1'b0, 1'b0);
`ifdef STL_RST_SWREQ_EN
    step(1'b1, 1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b0, 1'b0);
`endif
    lowrun = 0;
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 199);
      if (lowrun > 0) begin
        lowrun--;
        step(1'b0, 1'b0, 1'b0);
      end else if (r < 3) begin
        step(1'b1, 1'b1, 1'b0);
      end else if (r < 10) begin
        lowrun = $urandom_range(0, 4);
        step(1'b0, 1'b0, 1'b0);
      end else begin
`ifdef STL_RST_SWREQ_EN
        step(1'b1, 1'b0, (r >= 196) ? 1'b1 : 1'b0);
`else
        step(1'b1, 1'b0, 1'b0);
`endif
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stl_rst_seq.md
STL_RST_SEQ -- requirements
Module: stl_rst_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: i_clk (single clock domain) and i_rst (synchronous, active-high, sampled only on i_clk rising edge).
REQ-002 Parameter NUM_CH, default 4, range 1..16: number of sequenced reset outputs.
REQ-003 Parameter SYNC_STAGES, default 2, range 2..4: synchronizer depth for i_ext_rst_n.
REQ-004 Parameter MIN_ASSERT, default 16, range 1..255: minimum cycles all outputs stay asserted after the last active request.
REQ-005 Parameter RELEASE_GAP, default 8, range 1..255: cycles between consecutive channel releases.
REQ-006 Port i_clk, input, 1 bit: clock.
REQ-007 Port i_rst, input, 1 bit: synchronous active-high block reset.
REQ-008 Port i_ext_rst_n, input, 1 bit: asynchronous active-low external reset request.
REQ-009 Port i_sw_rst, input, 1 bit: synchronous software reset pulse; present only with STL_RST_SWREQ_EN.
REQ-010 Port o_rst_n, output, NUM_CH bits: registered active-low resets; bit 0 is released first.
REQ-011 Port o_done, output, 1 bit: high when all channels are released.

Function
REQ-012 i_ext_rst_n SHALL pass through SYNC_STAGES flops; the request is active when the final stage is 0.
REQ-013 The FSM SHALL have states ASSERT, RELEASE and DONE, with an 8-bit cycle counter cnt and a channel index idx.
REQ-014 ASSERT: o_rst_n all 0; cnt clears whenever the request is active, otherwise it increments.
REQ-015 ASSERT: at an edge with the request inactive and cnt==MIN_ASSERT-1, o_rst_n[0] SHALL go 1, cnt clear, idx=1, then RELEASE (or DONE if NUM_CH==1).
REQ-016 RELEASE: cnt increments; at an edge with cnt==RELEASE_GAP-1, o_rst_n[idx] SHALL go 1, cnt clear, idx increment.
REQ-017 The edge releasing channel NUM_CH-1 SHALL also enter DONE and set o_done.
REQ-018 A channel, once released, SHALL stay released until the next return to ASSERT.
REQ-019 An active request in RELEASE or DONE SHALL, at the same edge, drive all o_rst_n to 0, clear o_done, clear cnt, and enter ASSERT.
REQ-020 When the request is active and the counter is at terminal count at the same edge, the request SHALL win.
REQ-021 Counters SHALL never wrap; the parameter ranges keep terminal counts within 8 bits.

Reset
REQ-022 With i_rst high at an edge, the block SHALL enter ASSERT with cnt=0, idx=0, o_rst_n all 0, o_done=0, and all synchronizer stages 0.
REQ-023 i_rst high mid-sequence SHALL abort the sequence identically to REQ-022.
REQ-024 Outputs SHALL never release during i_rst high or within SYNC_STAGES+MIN_ASSERT edges after it falls.

Configuration
REQ-025 With macro STL_RST_SWREQ_EN defined, i_sw_rst high at an edge SHALL be treated as an active request without synchronization (same effect as REQ-019 at that edge, cnt held 0).
REQ-026 With STL_RST_SWREQ_EN undefined, port i_sw_rst and its logic SHALL be absent; behaviour is otherwise identical.

Verification
(All use NUM_CH=3, SYNC_STAGES=2, MIN_ASSERT=4, RELEASE_GAP=2, i_ext_rst_n=1.)
REQ-027 i_rst falls before edge 1 -> o_rst_n=000 through edge 5; 001 after edge 6; 011 after edge 8; 111 and o_done=1 after edge 10.
REQ-028 Drop i_ext_rst_n to 0 one cycle after o_rst_n=011 -> o_rst_n=000 and o_done=0 two edges later (sync latency); restore it -> the full REQ-027 timing repeats relative to restoration.
REQ-029 In ASSERT with cnt=3, i_ext_rst_n held low for 3 cycles -> cnt clears; release occurs only after 4 further inactive-request edges.
REQ-030 In DONE, assert i_rst for 1 cycle -> o_rst_n=000 and o_done=0 after that edge; then the REQ-027 timing repeats.
REQ-031 With STL_RST_SWREQ_EN: i_sw_rst pulse in DONE -> o_rst_n=000 at the next edge; 001 four edges after the pulse edge. Without STL_RST_SWREQ_EN: the build elaborates with no i_sw_rst port.
